sfifo_fwft: RTL and testbench
=============================

Name: sfifo_fwft

Overview:
- Single-clock, parametrised successor to the dual-clock FIFO, for same-domain buffering with no synchroniser latency.
- Adds runtime-visible occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags, a synchronous flush, and a selectable first-word-fall-through (FWFT) read mode.
- Storage is an internal register array; no external dual-port RAM is required.

Parameters:
- DATALEN, 8, data word width in bits.
- ADDRLEN, 3, storage address width; DEPTH = 2**ADDRLEN words. Pointers are ADDRLEN+1 bits.
- FWFT, 0, read mode: 0 = standard registered read; 1 = first-word-fall-through.
- AFULL_TH, 6, afull_o asserts when count >= AFULL_TH. Legal range 1..DEPTH.
- AEMPTY_TH, 1, aempty_o asserts when count <= AEMPTY_TH. Legal range 0..DEPTH-1.

Ports:
- clk  in  1  the only clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- clr  in  1  synchronous flush; priority over winc/rinc.
- winc  in  1  write request.
- wdata  in  DATALEN  write data.
- rinc  in  1  read request (pop).
- rdata_o  out  DATALEN  read data.
- full_o  out  1  FIFO full (count == DEPTH).
- empty_o  out  1  FIFO empty (count == 0).
- afull_o  out  1  almost full.
- aempty_o  out  1  almost empty.
- count_o  out  ADDRLEN+1  current occupancy, 0..DEPTH.
- ovf_o  out  1  sticky: write attempted while full.
- udf_o  out  1  sticky: read attempted while empty.

Behaviour:
- Reset (rst_n=0 at an edge): pointers 0, count_o=0, empty_o=1, full_o=0, aempty_o=1, afull_o=0, ovf_o=0, udf_o=0, rdata_o=0 (FWFT=0). Memory contents are not reset.
- Write accept: we = winc & ~full_o & ~clr, judged on the current registered full_o. On accept, mem[wptr[ADDRLEN-1:0]] <= wdata and wptr increments.
- Read accept: re = rinc & ~empty_o & ~clr, judged on the current registered empty_o. On accept, rptr increments.
- Pointer arithmetic: ADDRLEN+1 bit binary, wrapping naturally modulo 2*DEPTH. count = wptr - rptr, taken modulo 2**(ADDRLEN+1).
- All flags and count_o are registers computed from the next-state count. They reflect a write or read in the cycle after the accepting edge (1-cycle latency).
- Simultaneous accepted write and read: count unchanged, both pointers advance.
- Write while full, including when rinc is also asserted: the write is dropped and ovf_o <= 1. The read still proceeds. Full is never bypassed.
- Read while empty, including when winc is also asserted: the read is dropped and udf_o <= 1. rdata_o holds its value. The write proceeds.
- ovf_o and udf_o clear only on rst_n=0 or clr=1.
- FWFT=0: rdata_o is registered. It is loaded with mem[rptr] on the edge that accepts a read, so it is valid the cycle after re. It holds otherwise.
- FWFT=1: rdata_o = mem[rptr] combinationally from the register array. It is valid whenever empty_o=0. rinc consumes the displayed word. The first word appears the cycle after the write edge, together with empty_o falling.
- clr: pointers go to 0, count/flags go to reset values, and ovf_o/udf_o go to 0. Any winc/rinc in the same cycle is ignored without setting the error flags. rdata_o goes to 0 in FWFT=0.
- Reset mid-operation: identical to clr. In-flight data is discarded.

Decomposition:
- Shared package fifo_pkg:
  - a clog2 function;
  - localparam helpers for DEPTH and pointer width;
  - a read-mode constant pair FIFO_STD=0 / FIFO_FWFT=1.
- One sub-module, sfifo_regfile: DEPTH x DATALEN register array with synchronous write enable and asynchronous read port. It is reusable by later FIFO variants.
- Pointer, count and flag logic stay in sfifo_fwft.

Test Plan:
- Defaults (DATALEN=8, ADDRLEN=3, FWFT=0): after reset, write 0x11..0x18 on 8 consecutive cycles -> count_o steps 1..8, afull_o rises after the 6th write, full_o=1 after the 8th. A 9th write sets ovf_o=1 and count_o stays 8.
- From full, pop 8 times -> rdata_o = 0x11..0x18, each 1 cycle after its rinc. empty_o=1 after the last pop. A further rinc sets udf_o=1 and rdata_o stays 0x18.
- Wrap-around: run 20 write/read pairs with 3 words resident -> data returns in order across pointer wrap, and count_o stays 3 throughout.
- Simultaneous winc+rinc at full (count 8) -> write dropped, ovf_o=1, read accepted, count_o=7. Simultaneous winc+rinc at empty -> read dropped, udf_o=1, count_o=1.
- FWFT=1: write 0xA5 -> the next cycle shows empty_o=0 and rdata_o=0xA5 with no rinc. rinc then gives empty_o=1.
- clr with count 5 and ovf_o=1, winc=1 in the same cycle -> next cycle count_o=0, empty_o=1, ovf_o=0, and nothing is written. rst_n=0 mid-burst gives the same result.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the single-clock FIFO family: sizing helpers and read-mode constants.
package fifo_pkg;

  // Read-mode selector values for the FWFT parameter
  localparam int FIFO_STD  = 0;
  localparam int FIFO_FWFT = 1;

  // Ceiling log2, used to size address ports from a word count
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

  // Number of words addressed by an ADDRLEN-bit storage address
  function automatic int fifo_depth(input int addrlen);
    return 1 << addrlen;
  endfunction

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  function automatic int fifo_ptr_w(input int addrlen);
    return addrlen + 1;
  endfunction

  // Default geometry shared by the FIFO variants
  localparam int FIFO_DEF_ADDRLEN = 3;
  localparam int FIFO_DEF_DEPTH   = 1 << FIFO_DEF_ADDRLEN;
  localparam int FIFO_DEF_PTR_W   = FIFO_DEF_ADDRLEN + 1;

endpackage

// File: rtl/sfifo_regfile.sv
// DEPTH x DATALEN register array: synchronous write, asynchronous read.
module sfifo_regfile
  import fifo_pkg::*;
#(
  parameter int DATALEN = 8,
  parameter int DEPTH   = FIFO_DEF_DEPTH,
  parameter int ADDR_W  = clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [DATALEN-1:0] wdata,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [DATALEN-1:0] rdata
);

  logic [DATALEN-1:0] mem [DEPTH];

  // Storage is never reset; only written words are ever read back
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sfifo_fwft.sv
// Single-clock FIFO with occupancy count, almost flags, sticky error flags,
// synchronous flush and selectable standard / first-word-fall-through read.
module sfifo_fwft
  import fifo_pkg::*;
#(
  parameter int DATALEN   = 8,
  parameter int ADDRLEN   = FIFO_DEF_ADDRLEN,
  parameter int FWFT      = FIFO_STD,
  parameter int AFULL_TH  = 6,
  parameter int AEMPTY_TH = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               winc,
  input  logic [DATALEN-1:0] wdata,
  input  logic               rinc,
  output logic [DATALEN-1:0] rdata_o,
  output logic               full_o,
  output logic               empty_o,
  output logic               afull_o,
  output logic               aempty_o,
  output logic [ADDRLEN:0]   count_o,
  output logic               ovf_o,
  output logic               udf_o
);

  localparam int DEPTH = fifo_depth(ADDRLEN);
  localparam int PTR_W = fifo_ptr_w(ADDRLEN);

  localparam logic [PTR_W-1:0] DEPTH_C  = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] AFULL_C  = PTR_W'(AFULL_TH);
  localparam logic [PTR_W-1:0] AEMPTY_C = PTR_W'(AEMPTY_TH);

  logic [PTR_W-1:0]   wptr, rptr;
  logic [PTR_W-1:0]   wptr_nxt, rptr_nxt, count_nxt;
  logic               we, re;
  logic [DATALEN-1:0] mem_rdata;

  // Acceptance is judged on the registered flags, so full is never bypassed by a same-cycle read
  always_comb begin
    we        = winc & ~full_o & ~clr;
    re        = rinc & ~empty_o & ~clr;
    wptr_nxt  = wptr + PTR_W'(we);
    rptr_nxt  = rptr + PTR_W'(re);
    count_nxt = wptr_nxt - rptr_nxt;
  end

  // Pointers, count and flags; flush behaves exactly like reset
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      wptr     <= '0;
      rptr     <= '0;
      count_o  <= '0;
      full_o   <= 1'b0;
      empty_o  <= 1'b1;
      afull_o  <= (AFULL_C == '0);
      aempty_o <= 1'b1;
      ovf_o    <= 1'b0;
      udf_o    <= 1'b0;
    end else begin
      wptr     <= wptr_nxt;
      rptr     <= rptr_nxt;
      count_o  <= count_nxt;
      full_o   <= (count_nxt == DEPTH_C);
      empty_o  <= (count_nxt == '0);
      afull_o  <= (count_nxt >= AFULL_C);
      aempty_o <= (count_nxt <= AEMPTY_C);
      ovf_o    <= ovf_o | (winc & full_o);
      udf_o    <= udf_o | (rinc & empty_o);
    end
  end

  sfifo_regfile #(
    .DATALEN (DATALEN),
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDRLEN)
  ) u_regfile (
    .clk   (clk),
    .we    (we),
    .waddr (wptr[ADDRLEN-1:0]),
    .wdata (wdata),
    .raddr (rptr[ADDRLEN-1:0]),
    .rdata (mem_rdata)
  );

  generate
    if (FWFT == FIFO_FWFT) begin : g_fwft
      // Head word is shown directly; it is valid whenever empty_o is low
      assign rdata_o = mem_rdata;
    end else begin : g_std
      // Registered read: head word captured on the edge that pops it
      always_ff @(posedge clk) begin
        if (!rst_n || clr) rdata_o <= '0;
        else if (re)       rdata_o <= mem_rdata;
      end
    end
  endgenerate

endmodule

// File: tb/tb_sfifo_fwft.sv
// Self-checking bench for sfifo_fwft: standard-read instance driven from a vector
// table plus a queue scoreboard, and a fall-through instance with short sequences.
module tb_sfifo_fwft;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Standard-read instance
  logic       a_rst_n, a_clr, a_winc, a_rinc;
  logic [7:0] a_wdata, a_rdata;
  logic       a_full, a_empty, a_afull, a_aempty, a_ovf, a_udf;
  logic [3:0] a_count;

  // Fall-through instance
  logic       b_rst_n, b_clr, b_winc, b_rinc;
  logic [7:0] b_wdata, b_rdata;
  logic       b_full, b_empty, b_afull, b_aempty, b_ovf, b_udf;
  logic [3:0] b_count;

  sfifo_fwft #(.DATALEN(8), .ADDRLEN(3), .FWFT(0), .AFULL_TH(6), .AEMPTY_TH(1)) dut_a (
    .clk(clk), .rst_n(a_rst_n), .clr(a_clr), .winc(a_winc), .wdata(a_wdata), .rinc(a_rinc),
    .rdata_o(a_rdata), .full_o(a_full), .empty_o(a_empty), .afull_o(a_afull),
    .aempty_o(a_aempty), .count_o(a_count), .ovf_o(a_ovf), .udf_o(a_udf));

  sfifo_fwft #(.DATALEN(8), .ADDRLEN(3), .FWFT(1), .AFULL_TH(6), .AEMPTY_TH(1)) dut_b (
    .clk(clk), .rst_n(b_rst_n), .clr(b_clr), .winc(b_winc), .wdata(b_wdata), .rinc(b_rinc),
    .rdata_o(b_rdata), .full_o(b_full), .empty_o(b_empty), .afull_o(b_afull),
    .aempty_o(b_aempty), .count_o(b_count), .ovf_o(b_ovf), .udf_o(b_udf));

  int checks = 0;
  int errors = 0;

  // Scoreboard / reference state for the standard-read instance
  logic [7:0] q[$];
  logic       movf = 1'b0;
  logic       mudf = 1'b0;
  logic [7:0] mlast = 8'h00;

  typedef struct {
    logic       w;
    logic       r;
    logic [7:0] d;
    int         cnt;
    logic       full;
    logic       empty;
    logic       afull;
    logic       aempty;
    logic       ovf;
    logic       udf;
  } vec_t;

  vec_t tbl[18];

  function automatic vec_t mk(logic w, logic r, logic [7:0] d, int cnt, logic full, logic empty,
                              logic afull, logic aempty, logic ovf, logic udf);
    vec_t v;
    v.w = w; v.r = r; v.d = d; v.cnt = cnt; v.full = full; v.empty = empty;
    v.afull = afull; v.aempty = aempty; v.ovf = ovf; v.udf = udf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One clock on the standard instance; the scoreboard follows what the FIFO should accept
  task automatic cyc_a(input logic w, input logic r, input logic c, input logic rn, input logic [7:0] d);
    logic wacc, racc;
    a_winc = w; a_rinc = r; a_clr = c; a_rst_n = rn; a_wdata = d;
    @(posedge clk);
    #1;
    if (!rn || c) begin
      q.delete();
      movf  = 1'b0;
      mudf  = 1'b0;
      mlast = 8'h00;
    end else begin
      wacc = w && (q.size() < 8);
      racc = r && (q.size() != 0);
      if (w && !wacc) movf = 1'b1;
      if (r && !racc) mudf = 1'b1;
      if (racc) mlast = q.pop_front();
      if (wacc) q.push_back(d);
    end
    a_winc = 1'b0; a_rinc = 1'b0; a_clr = 1'b0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_count"},  32'(a_count),  32'(q.size()));
    chk({tag, "_full"},   32'(a_full),   32'(q.size() == 8));
    chk({tag, "_empty"},  32'(a_empty),  32'(q.size() == 0));
    chk({tag, "_afull"},  32'(a_afull),  32'(q.size() >= 6));
    chk({tag, "_aempty"}, 32'(a_aempty), 32'(q.size() <= 1));
    chk({tag, "_ovf"},    32'(a_ovf),    32'(movf));
    chk({tag, "_udf"},    32'(a_udf),    32'(mudf));
    chk({tag, "_rdata"},  32'(a_rdata),  32'(mlast));
  endtask

  task automatic cyc_b(input logic w, input logic r, input logic [7:0] d);
    b_winc = w; b_rinc = r; b_wdata = d;
    @(posedge clk);
    #1;
    b_winc = 1'b0; b_rinc = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    a_rst_n = 1'b0; a_clr = 1'b0; a_winc = 1'b0; a_rinc = 1'b0; a_wdata = 8'h00;
    b_rst_n = 1'b0; b_clr = 1'b0; b_winc = 1'b0; b_rinc = 1'b0; b_wdata = 8'h00;

    // Fill to full, overflow, drain to empty, underflow
    tbl[0]  = mk(1, 0, 8'h11, 1, 0, 0, 0, 1, 0, 0);
    tbl[1]  = mk(1, 0, 8'h12, 2, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(1, 0, 8'h13, 3, 0, 0, 0, 0, 0, 0);
    tbl[3]  = mk(1, 0, 8'h14, 4, 0, 0, 0, 0, 0, 0);
    tbl[4]  = mk(1, 0, 8'h15, 5, 0, 0, 0, 0, 0, 0);
    tbl[5]  = mk(1, 0, 8'h16, 6, 0, 0, 1, 0, 0, 0);
    tbl[6]  = mk(1, 0, 8'h17, 7, 0, 0, 1, 0, 0, 0);
    tbl[7]  = mk(1, 0, 8'h18, 8, 1, 0, 1, 0, 0, 0);
    tbl[8]  = mk(1, 0, 8'h99, 8, 1, 0, 1, 0, 1, 0);
    tbl[9]  = mk(0, 1, 8'h00, 7, 0, 0, 1, 0, 1, 0);
    tbl[10] = mk(0, 1, 8'h00, 6, 0, 0, 1, 0, 1, 0);
    tbl[11] = mk(0, 1, 8'h00, 5, 0, 0, 0, 0, 1, 0);
    tbl[12] = mk(0, 1, 8'h00, 4, 0, 0, 0, 0, 1, 0);
    tbl[13] = mk(0, 1, 8'h00, 3, 0, 0, 0, 0, 1, 0);
    tbl[14] = mk(0, 1, 8'h00, 2, 0, 0, 0, 0, 1, 0);
    tbl[15] = mk(0, 1, 8'h00, 1, 0, 0, 0, 1, 1, 0);
    tbl[16] = mk(0, 1, 8'h00, 0, 0, 1, 0, 1, 1, 0);
    tbl[17] = mk(0, 1, 8'h00, 0, 0, 1, 0, 1, 1, 1);

    // Reset state
    cyc_a(0, 0, 0, 0, 8'h00);
    cyc_a(0, 0, 0, 0, 8'h00);
    check_model("reset");

    for (int i = 0; i < 18; i++) begin
      cyc_a(tbl[i].w, tbl[i].r, 1'b0, 1'b1, tbl[i].d);
      chk($sformatf("tbl%0d_count", i),  32'(a_count),  32'(tbl[i].cnt));
      chk($sformatf("tbl%0d_full", i),   32'(a_full),   32'(tbl[i].full));
      chk($sformatf("tbl%0d_empty", i),  32'(a_empty),  32'(tbl[i].empty));
      chk($sformatf("tbl%0d_afull", i),  32'(a_afull),  32'(tbl[i].afull));
      chk($sformatf("tbl%0d_aempty", i), 32'(a_aempty), 32'(tbl[i].aempty));
      chk($sformatf("tbl%0d_ovf", i),    32'(a_ovf),    32'(tbl[i].ovf));
      chk($sformatf("tbl%0d_udf", i),    32'(a_udf),    32'(tbl[i].udf));
      chk($sformatf("tbl%0d_rdata", i),  32'(a_rdata),  32'(mlast));
    end
    chk("drain_last_word", 32'(a_rdata), 32'h18);

    // Flush with count 5, ovf set and a concurrent write
    cyc_a(1, 0, 0, 1, 8'h21);
    cyc_a(1, 0, 0, 1, 8'h22);
    cyc_a(1, 0, 0, 1, 8'h23);
    cyc_a(1, 0, 0, 1, 8'h24);
    cyc_a(1, 0, 0, 1, 8'h25);
    check_model("pre_clr");
    cyc_a(1, 0, 1, 1, 8'hEE);
    check_model("clr");
    chk("clr_count_zero", 32'(a_count), 32'd0);
    chk("clr_ovf_zero",   32'(a_ovf),   32'd0);
    cyc_a(1, 0, 0, 1, 8'h5A);
    cyc_a(0, 1, 0, 1, 8'h00);
    check_model("post_clr_rd");
    chk("post_clr_data", 32'(a_rdata), 32'h5A);

    // Wrap-around with three words resident
    cyc_a(1, 0, 0, 1, 8'h30);
    cyc_a(1, 0, 0, 1, 8'h31);
    cyc_a(1, 0, 0, 1, 8'h32);
    for (int i = 0; i < 20; i++) begin
      cyc_a(1, 1, 0, 1, 8'(8'h40 + i));
      check_model($sformatf("wrap%0d", i));
      chk($sformatf("wrap%0d_cnt3", i), 32'(a_count), 32'd3);
    end

    // Simultaneous write+read at full
    cyc_a(0, 0, 1, 1, 8'h00);
    for (int i = 0; i < 8; i++) cyc_a(1, 0, 0, 1, 8'(8'h60 + i));
    check_model("full8");
    cyc_a(1, 1, 0, 1, 8'hF0);
    check_model("wr_rd_full");
    chk("wr_rd_full_cnt", 32'(a_count), 32'd7);
    chk("wr_rd_full_ovf", 32'(a_ovf),   32'd1);
    chk("wr_rd_full_dat", 32'(a_rdata), 32'h60);

    // Simultaneous write+read at empty
    cyc_a(0, 0, 1, 1, 8'h00);
    cyc_a(1, 1, 0, 1, 8'hC3);
    check_model("wr_rd_empty");
    chk("wr_rd_empty_cnt", 32'(a_count), 32'd1);
    chk("wr_rd_empty_udf", 32'(a_udf),   32'd1);

    // Reset mid-burst with a concurrent write
    cyc_a(1, 0, 0, 1, 8'h71);
    cyc_a(1, 0, 0, 1, 8'h72);
    cyc_a(1, 0, 0, 0, 8'h73);
    check_model("mid_rst");
    chk("mid_rst_udf", 32'(a_udf), 32'd0);
    cyc_a(0, 0, 0, 1, 8'h00);
    cyc_a(0, 1, 0, 1, 8'h00);
    check_model("mid_rst_after");

    // Fall-through instance
    cyc_b(0, 0, 8'h00);
    cyc_b(0, 0, 8'h00);
    b_rst_n = 1'b1;
    chk("b_reset_empty", 32'(b_empty), 32'd1);
    chk("b_reset_count", 32'(b_count), 32'd0);
    cyc_b(1, 0, 8'hA5);
    chk("b_first_empty", 32'(b_empty), 32'd0);
    chk("b_first_data",  32'(b_rdata), 32'hA5);
    cyc_b(0, 0, 8'h00);
    chk("b_hold_data",   32'(b_rdata), 32'hA5);
    cyc_b(0, 1, 8'h00);
    chk("b_pop_empty",   32'(b_empty), 32'd1);
    chk("b_pop_count",   32'(b_count), 32'd0);
    cyc_b(1, 0, 8'h3C);
    cyc_b(1, 0, 8'h7E);
    chk("b_head0", 32'(b_rdata), 32'h3C);
    cyc_b(0, 1, 8'h00);
    chk("b_head1", 32'(b_rdata), 32'h7E);
    chk("b_cnt1",  32'(b_count), 32'd1);
    cyc_b(0, 1, 8'h00);
    cyc_b(0, 1, 8'h00);
    chk("b_udf",   32'(b_udf),   32'd1);
    chk("b_empty_end", 32'(b_empty), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
